// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment constants and scan FSM state type
//
// Purpose: active-low 7-segment patterns ({g,f,e,d,c,b,a}) for digits 0-9,
//          the blank pattern, and the scan-decoder FSM state enumeration.
// Ports:   none (package).
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HELD   = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational active-low 7-segment pattern to BCD decoder
//
// Purpose: maps one active-low segment pattern to its BCD digit. Patterns
//          that are not one of the ten digits (blank included) give 4'hF
//          with o_valid low.
// Ports:   i_seg    [6:0] segment pattern {g,f,e,d,c,b,a}, active-low
//          o_valid        1 when i_seg is a legal digit 0-9
//          o_nibble [3:0] decoded digit, 4'hF when invalid
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_valid,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_valid  = 1'b1;
    o_nibble = 4'hF;
    case (i_seg)
      SEG_0:   o_nibble = 4'd0;
      SEG_1:   o_nibble = 4'd1;
      SEG_2:   o_nibble = 4'd2;
      SEG_3:   o_nibble = 4'd3;
      SEG_4:   o_nibble = 4'd4;
      SEG_5:   o_nibble = 4'd5;
      SEG_6:   o_nibble = 4'd6;
      SEG_7:   o_nibble = 4'd7;
      SEG_8:   o_nibble = 4'd8;
      SEG_9:   o_nibble = 4'd9;
      default: begin
        o_valid  = 1'b0;
        o_nibble = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - reconstructs four BCD digits from multiplexed 7-seg scan lines
//
// Purpose: samples seg/sel, waits for each digit to be stable for STABLE_CNT
//          samples, collects four digits into a frame and publishes it.
// Ports:   sys_clk           system clock
//          sys_rst_p         synchronous active-high reset
//          seg         [6:0] segment lines, active-low {g,f,e,d,c,b,a}
//          sel         [3:0] digit selects, active-low, sel[0] = least significant
//          data       [15:0] last complete frame {d3,d2,d1,d0}
//          frame_valid       one-cycle pulse when data updates
//          changed           pulse with frame_valid when data differs from previous frame
//          pat_err           pulse with frame_valid when any digit of the frame was invalid
//          sel_err           sticky, set when more than one sel line is low
//          stale             high while no digit has been accepted for TIMEOUT cycles
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CNT = 16,
  parameter int TIMEOUT    = 1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_p,
  input  logic [6:0]  seg,
  input  logic [3:0]  sel,
  output logic [15:0] data,
  output logic        frame_valid,
  output logic        changed,
  output logic        pat_err,
  output logic        sel_err,
  output logic        stale
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  // Input sample registers and the previous sample for stability compare
  logic [6:0]        r_seg_q;
  logic [3:0]        r_sel_q;
  logic [10:0]       r_prev;

  scan_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [TO_W-1:0]   r_to_cnt;

  logic [15:0]       r_shadow;
  logic [3:0]        r_mask;
  logic [3:0]        r_inv;

  logic [15:0]       r_data;
  logic              r_frame_valid;
  logic              r_changed;
  logic              r_pat_err;
  logic              r_sel_err;
  logic              r_stale;

  logic [3:0]        w_low;
  logic              w_multi;
  logic              w_onehot;
  logic              w_same;
  logic [1:0]        w_idx;
  logic              w_accept;
  logic              w_valid;
  logic [3:0]        w_nibble;

  seg7_to_bcd u_dec (
    .i_seg    (r_seg_q),
    .o_valid  (w_valid),
    .o_nibble (w_nibble)
  );

  // sel is active-low; x & (x-1) clears the lowest set bit, so a nonzero
  // remainder means two or more selects are asserted.
  assign w_low    = ~r_sel_q;
  assign w_multi  = (w_low & (w_low - 4'd1)) != 4'd0;
  assign w_onehot = (w_low != 4'd0) && !w_multi;
  assign w_same   = ({r_sel_q, r_seg_q} == r_prev);

  always_comb begin
    w_idx = 2'd0;
    case (w_low)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  // The sample that brings the run length to STABLE_CNT accepts the digit
  assign w_accept = w_onehot && (r_state == S_SETTLE) && w_same && (r_cnt == CNT_LAST);

  // Input registers, scan FSM and sticky select error
  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      r_seg_q   <= SEG_BLANK;
      r_sel_q   <= 4'hF;
      r_prev    <= '1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_seg_q <= seg;
      r_sel_q <= sel;
      r_prev  <= {r_sel_q, r_seg_q};

      if (w_multi) begin
        r_sel_err <= 1'b1;
      end

      if (!w_onehot) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            // First one-hot sample of a dwell counts as one
            r_state <= S_SETTLE;
            r_cnt   <= CNT_ONE;
          end
          S_SETTLE: begin
            if (!w_same) begin
              r_cnt <= CNT_ONE;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
              if (w_accept) begin
                r_state <= S_HELD;
              end
            end
          end
          S_HELD: begin
            if (!w_same) begin
              r_state <= S_SETTLE;
              r_cnt   <= CNT_ONE;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Shadow frame assembly and frame publication
  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      r_shadow      <= '0;
      r_mask        <= '0;
      r_inv         <= '0;
      r_data        <= '0;
      r_frame_valid <= 1'b0;
      r_changed     <= 1'b0;
      r_pat_err     <= 1'b0;
    end else begin
      if (r_mask == 4'hF) begin
        r_data        <= r_shadow;
        r_frame_valid <= 1'b1;
        r_changed     <= (r_shadow != r_data);
        r_pat_err     <= |r_inv;
        r_mask        <= '0;
        r_inv         <= '0;
      end else begin
        r_frame_valid <= 1'b0;
        r_changed     <= 1'b0;
        r_pat_err     <= 1'b0;
      end

      // Placed after the frame clear so an accept in the same cycle survives
      if (w_accept) begin
        r_shadow[{w_idx, 2'b00} +: 4] <= w_nibble;
        r_mask[w_idx]                 <= 1'b1;
        r_inv[w_idx]                  <= ~w_valid;
      end
    end
  end

  // Timeout counter; stale is registered from the counter's next value so it
  // tracks counter == TIMEOUT exactly.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_to_cnt <= '0;
        r_stale  <= 1'b0;
      end else begin
        if (r_to_cnt != TO_MAX) begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
        r_stale <= (r_to_cnt >= TO_LAST);
      end
    end
  end

  assign data        = r_data;
  assign frame_valid = r_frame_valid;
  assign changed     = r_changed;
  assign pat_err     = r_pat_err;
  assign sel_err     = r_sel_err;
  assign stale       = r_stale;

endmodule
